// File: rtl/bmult_10x10.sv
// bmult_10x10: 10x10 radix-4 Booth multiplier with a single registered
// 20-bit product (1-cycle latency, one multiply per clock).
// Optional build macro BMULT_SIGNED_EN selects two's complement operands
// and product; when undefined, operands and product are unsigned.

// One Booth partial-product row: selects 0/+-A/+-2A from a 3-bit digit
// window and returns the row with its sign bit inverted, ready for the
// constant sign-extension correction applied in the reduction.
module bmult_booth_pp (
    input  logic [2:0]  i_dig,
    input  logic [11:0] i_a,
    output logic [11:0] o_pp,
    output logic        o_neg
);
    logic        w_one;
    logic        w_two;
    logic [11:0] w_mag;
    logic [11:0] w_sel;

    assign w_one = i_dig[0] ^ i_dig[1];
    assign w_two = (i_dig[2] & ~i_dig[1] & ~i_dig[0]) |
                   (~i_dig[2] & i_dig[1] & i_dig[0]);
    // Digit 111 is -0: treated as +0 so no correction bit is injected.
    assign o_neg = i_dig[2] & ~(i_dig[1] & i_dig[0]);

    // Magnitude select and conditional inversion (the +1 goes in the LSB column).
    always_comb begin
        w_mag = 12'h000;
        if (w_one)
            w_mag = i_a;
        else if (w_two)
            w_mag = {i_a[10:0], 1'b0};
        w_sel = o_neg ? ~w_mag : w_mag;
        o_pp  = {~w_sel[11], w_sel[10:0]};
    end
endmodule

module bmult_10x10 (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  A,
    input  logic [9:0]  B,
    output logic [19:0] P
);
`ifdef BMULT_SIGNED_EN
    localparam int NPP = 5;
`else
    localparam int NPP = 6;
`endif
    localparam int BW = 2 * NPP + 1;
    // Inverting each row's sign bit adds 2^(11+2i) per row; this constant
    // is minus that sum mod 2^20 (identical for 5 and 6 rows since the
    // sixth term lands at 2^21).
    localparam logic [19:0] SE_CONST = 20'h55800;

    logic [BW-1:0]         w_bext;
    logic [11:0]           w_aext;
    logic [NPP-1:0][11:0]  w_pp;
    logic [NPP-1:0]        w_neg;
    logic [19:0]           w_corr;
    logic [19:0]           w_sum;
    logic [19:0]           w_cry;
    logic [19:0]           w_row;
    logic [18:0]           w_maj;
    logic [19:0]           w_prod;

    // B with the implicit zero below bit 0; A extended to the 12-bit +-2A range.
`ifdef BMULT_SIGNED_EN
    assign w_bext = {B, 1'b0};
    assign w_aext = {{2{A[9]}}, A};
`else
    assign w_bext = {2'b00, B, 1'b0};
    assign w_aext = {2'b00, A};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NPP; gi++) begin : g_pp
            bmult_booth_pp u_pp (
                .i_dig (w_bext[2*gi+2 -: 3]),
                .i_a   (w_aext),
                .o_pp  (w_pp[gi]),
                .o_neg (w_neg[gi])
            );
        end
    endgenerate

    // Carry-save reduction: the correction row (sign constant plus the
    // per-row +1 bits, which occupy disjoint columns) seeds the carry row,
    // then each shifted partial product is folded in with a 3:2 compressor.
    always_comb begin
        w_corr = SE_CONST;
        for (int i = 0; i < NPP; i++)
            w_corr[2*i] = w_neg[i];
        w_sum = {8'h00, w_pp[0]};
        w_cry = w_corr;
        w_row = 20'h00000;
        w_maj = 19'h00000;
        for (int i = 1; i < NPP; i++) begin
            w_row = {8'h00, w_pp[i]} << (2 * i);
            w_maj = (w_sum[18:0] & w_cry[18:0]) |
                    (w_sum[18:0] & w_row[18:0]) |
                    (w_cry[18:0] & w_row[18:0]);
            w_sum = w_sum ^ w_cry ^ w_row;
            w_cry = {w_maj, 1'b0};
        end
    end

    // Final carry-propagate add, result taken mod 2^20.
    assign w_prod = w_sum + w_cry;

    // Single output register; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            P <= 20'h00000;
        else
            P <= w_prod;
    end
endmodule

// File: tb/tb_bmult_10x10.sv
module tb_bmult_10x10;
    logic        clk;
    logic        rst;
    logic [9:0]  A;
    logic [9:0]  B;
    logic [19:0] P;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;
    logic [19:0] m_exp;

    bmult_10x10 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .P   (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product straight from integer arithmetic.
    function automatic logic [19:0] prod(input logic [9:0] a, input logic [9:0] b);
`ifdef BMULT_SIGNED_EN
        int sa;
        int sb;
        int p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[19:0];
`else
        logic [19:0] p;
        p = {10'h000, a} * {10'h000, b};
        return p;
`endif
    endfunction

    function automatic logic [9:0] pick();
        case ($urandom_range(0, 7))
            0: return 10'h000;
            1: return 10'h3FF;
            2: return 10'h200;
            3: return 10'h1FF;
            default: return 10'($urandom);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    endtask

    // Model: P is the product of whatever sat on A/B at the last edge,
    // forced to zero by reset at once.
    always @(posedge clk or posedge rst) begin
        if (rst)
            m_exp <= 20'h00000;
        else
            m_exp <= prod(A, B);
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en)
            chk("pipe", P, m_exp);
    end

`ifdef BMULT_SIGNED_EN
    localparam int NV = 5;
    logic [9:0]  ta [NV] = '{10'h3FF, 10'h200, 10'h200, 10'h3FF, 10'h000};
    logic [9:0]  tb [NV] = '{10'h001, 10'h200, 10'h1FF, 10'h3FF, 10'h200};
    logic [19:0] tp [NV] = '{20'hFFFFF, 20'h40000, 20'hC0200, 20'h00001, 20'h00000};
`else
    localparam int NV = 7;
    logic [9:0]  ta [NV] = '{10'h3FF, 10'h000, 10'h001, 10'h200, 10'h3FF, 10'h3FF, 10'h2AB};
    logic [9:0]  tb [NV] = '{10'h3FF, 10'h2AB, 10'h3FF, 10'h200, 10'h155, 10'h2AA, 10'h000};
    logic [19:0] tp [NV] = '{20'hFF801, 20'h00000, 20'h003FF, 20'h40000, 20'h552AB, 20'hAA556, 20'h00000};
`endif

    initial begin
        rst = 1'b0;
        A   = 10'h3FF;
        B   = 10'h3FF;
        #1 rst = 1'b1;
        #1 chk("rst_immediate", P, 20'h00000);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_hold", P, 20'h00000);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_release", P, prod(10'h3FF, 10'h3FF));
`ifdef BMULT_SIGNED_EN
        chk("rst_release_lit", P, 20'h00001);
`else
        chk("rst_release_lit", P, 20'hFF801);
`endif

        // Directed corners back-to-back; each checked one edge later.
        for (int k = 0; k <= NV; k++) begin
            @(posedge clk);
            #1;
            if (k > 0) begin
                chk($sformatf("dir%0d", k - 1), P, tp[k - 1]);
                chk($sformatf("model%0d", k - 1), prod(ta[k - 1], tb[k - 1]), tp[k - 1]);
            end
            if (k < NV) begin
                #1;
                A = ta[k];
                B = tb[k];
            end
        end

        // Random stream with an asynchronous reset pulse in the middle.
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            #2;
            A = pick();
            B = pick();
            if (k == 10000) begin
                #1 rst = 1'b1;
                #1 chk("mid_rst_async", P, 20'h00000);
                repeat (3) @(posedge clk);
                #1 chk("mid_rst_hold", P, 20'h00000);
                #2 rst = 1'b0;
                @(posedge clk);
                #1 chk("mid_rst_resume", P, prod(A, B));
            end
        end

        @(posedge clk);
        #1 chk("final", P, prod(A, B));
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
